// File: rtl/inst_encoder_loader_if.sv
// Bundle stream into the encoder/loader and its instruction-memory write and status side.
interface inst_encoder_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        inst_type;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [11:0]       csr;
    logic [31:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              full;
    logic              err;
    logic [7:0]        err_count;

    modport master (
        output start, base_addr, in_valid, in_last, inst_type, rd, rs1, rs2,
               funct3, funct7, csr, imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err, err_count
    );

    modport slave (
        input  start, base_addr, in_valid, in_last, inst_type, rd, rs1, rs2,
               funct3, funct7, csr, imm,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, full, err, err_count
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs decoded RV32 field bundles into instruction words and writes them sequentially to imem.
// Define ENC_NOP_PAD_EN to pad each session with NOPs up to a multiple of four written words.
module inst_encoder_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4096
) (
    input logic                  clk,
    input logic                  rst,
    inst_encoder_loader_if.slave bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_CSR  = 7'b1110011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  wcnt_nxt;
    logic              full_q;
    logic              full_nxt;
    logic              err_q;
    logic              err_nxt;
    logic [7:0]        errc_q;
    logic [7:0]        errc_nxt;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wdata_nxt;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              done_nxt;

    logic [31:0] enc_word;
    logic        legal;
    logic        fits_i;
    logic        fits_b;
    logic        fits_j;
    logic        accept;
    logic        discard;
    logic        session_start;
    logic        wr;
    logic        pad_pending;
    logic        pad_pending_nxt;

    // Field packing and immediate range checks for each supported type
    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
        fits_i   = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
        fits_b   = ((&bus.imm[31:12]) | ~(|bus.imm[31:12])) & ~bus.imm[0];
        fits_j   = ((&bus.imm[31:20]) | ~(|bus.imm[31:20])) & ~bus.imm[0];
        case (bus.inst_type)
            3'b000: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
            3'b001: begin
                enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_I};
                legal    = fits_i;
            end
            3'b010: begin
                enc_word = {bus.imm[19:0], bus.rd, OP_LUI};
                legal    = ~(|bus.imm[31:20]);
            end
            3'b011: enc_word = {bus.csr, bus.rs1, bus.funct3, bus.rd, OP_CSR};
            3'b100: begin
                enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.imm[4:1], bus.imm[11], OP_B};
                legal    = fits_b;
            end
            3'b101: begin
                enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, OP_JAL};
                legal    = fits_j;
            end
            3'b110: begin
                enc_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, OP_JALR};
                legal    = fits_i;
            end
            default: legal = 1'b0;
        endcase
    end

    // Session control, write issue and sticky status next-state
    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        full_nxt      = full_q;
        err_nxt       = err_q;
        errc_nxt      = errc_q;
        wdata_nxt     = enc_word;
        accept        = 1'b0;
        discard       = 1'b0;
        session_start = 1'b0;
        wr            = 1'b0;
`ifdef ENC_NOP_PAD_EN
        pad_pending   = (wcnt[1:0] != 2'b00) && !full_q;
`else
        pad_pending   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    session_start = 1'b1;
                    state_nxt     = ST_RUN;
                    wcnt_nxt      = '0;
                    full_nxt      = 1'b0;
                    err_nxt       = 1'b0;
                    errc_nxt      = '0;
                end
            end
            ST_RUN: begin
                accept  = bus.in_valid && ready_q;
                discard = bus.in_valid && bus.in_last && full_q;
                wr      = accept && legal;
                if ((accept || discard) && !legal) begin
                    err_nxt = 1'b1;
                    if (errc_q != 8'hFF) errc_nxt = errc_q + 8'd1;
                end
                if ((accept && bus.in_last) || discard) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pad_pending) begin
                    wr        = 1'b1;
                    wdata_nxt = NOP_WORD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (wr) begin
            wcnt_nxt = wcnt + CNT_W'(1);
            if (wcnt_nxt == CNT_W'(DEPTH)) full_nxt = 1'b1;
        end
`ifdef ENC_NOP_PAD_EN
        pad_pending_nxt = (wcnt_nxt[1:0] != 2'b00) && !full_nxt;
`else
        pad_pending_nxt = 1'b0;
`endif
        // done coincides with the session's final write (or the lone drain cycle)
        done_nxt = (state_nxt == ST_DRAIN) && !pad_pending_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wcnt    <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            errc_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            full_q  <= full_nxt;
            err_q   <= err_nxt;
            errc_q  <= errc_nxt;
            we_q    <= wr;
            ready_q <= (state_nxt == ST_RUN) && !full_nxt;
            busy_q  <= (state_nxt != ST_IDLE);
            done_q  <= done_nxt;
            if (session_start) begin
                addr_q <= bus.base_addr;
            end else if (wr) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (wr) begin
                waddr_q <= addr_q;
                wdata_q <= wdata_nxt;
            end
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.full       = full_q;
    assign bus.err        = err_q;
    assign bus.err_count  = errc_q;
endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed vector bench for inst_encoder_loader (DEPTH=8 so the full path is reachable).
module tb_inst_encoder_loader;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 8;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        new_sess;
        logic [11:0] base;
        logic [2:0]  t;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] csr;
        logic [31:0] imm;
        logic        last;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_errc;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic ns, input logic [11:0] base, input logic [2:0] t,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7, input logic [11:0] csr,
                                input logic [31:0] imm, input logic last, input logic we,
                                input logic [11:0] addr, input logic [31:0] wdata,
                                input logic [7:0] errc);
        vec_t v;
        v.new_sess = ns;  v.base = base; v.t = t; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.csr = csr; v.imm = imm; v.last = last; v.exp_we = we;
        v.exp_addr = addr; v.exp_wdata = wdata; v.exp_errc = errc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.inst_type = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.funct3 = '0;
        bus.funct7 = '0; bus.csr = '0; bus.imm = '0;
    endtask

    task automatic set_beat(input vec_t v);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_last = v.last; bus.inst_type = v.t;
        bus.rd = v.rd; bus.rs1 = v.rs1; bus.rs2 = v.rs2; bus.funct3 = v.f3;
        bus.funct7 = v.f7; bus.csr = v.csr; bus.imm = v.imm;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy still 1 after 20 cycles, want 0");
        end
    endtask

    task automatic start_session(input logic [11:0] base);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_ready", 32'(bus.in_ready), 32'd1);
        chk("start_full", 32'(bus.full), 32'd0);
        chk("start_errc", 32'(bus.err_count), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, 32'(bus.imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_full"}, 32'(bus.full), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_errc"}, 32'(bus.err_count), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(1, 12'h010, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h000, 32'd0,          1, 1, 12'h010, 32'h002081B3, 8'd0);
        vecs[1]  = mk(1, 12'h010, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'hFFFFFFFF,   0, 1, 12'h010, 32'hFFF00293, 8'd0);
        vecs[2]  = mk(0, 12'h000, 3'd2, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h00012345,   1, 1, 12'h011, 32'h12345137, 8'd0);
        vecs[3]  = mk(1, 12'h020, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 12'h000, 32'hFFFFFFF8,   0, 1, 12'h020, 32'hFE208CE3, 8'd0);
        vecs[4]  = mk(0, 12'h000, 3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'hFFFFFFFE,   0, 1, 12'h021, 32'hFFFFF06F, 8'd0);
        vecs[5]  = mk(0, 12'h000, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'd16,         1, 1, 12'h022, 32'h010000EF, 8'd0);
        vecs[6]  = mk(1, 12'h030, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 12'h000, 32'd3,          0, 0, 12'h000, 32'h0,        8'd1);
        vecs[7]  = mk(0, 12'h000, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'd2048,       0, 0, 12'h000, 32'h0,        8'd2);
        vecs[8]  = mk(0, 12'h000, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 12'h000, 32'd0,          1, 1, 12'h030, 32'h002081B3, 8'd2);
        vecs[9]  = mk(1, 12'hFFF, 3'd3, 5'd0, 5'd5, 5'd0, 3'd1, 7'h00, 12'h305, 32'd0,          0, 1, 12'hFFF, 32'h30529073, 8'd0);
        vecs[10] = mk(0, 12'h000, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 12'h000, 32'd0,          0, 1, 12'h000, 32'h403100B3, 8'd0);
        vecs[11] = mk(0, 12'h000, 3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 12'h000, 32'd0,          0, 0, 12'h000, 32'h0,        8'd1);
        vecs[12] = mk(0, 12'h000, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h00100000,   0, 0, 12'h000, 32'h0,        8'd2);
        vecs[13] = mk(0, 12'h000, 3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'h00100000,   0, 0, 12'h000, 32'h0,        8'd3);
        vecs[14] = mk(0, 12'h000, 3'd6, 5'd1, 5'd6, 5'd0, 3'd7, 7'h00, 12'h000, 32'hFFFFFFFC,   1, 1, 12'h001, 32'hFFC300E7, 8'd3);

        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table: each vector is one beat, its write observed on the following cycle
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].new_sess) begin
                wait_idle();
                start_session(vecs[i].base);
            end
            @(negedge clk);
            set_beat(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i), 32'(bus.imem_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_addr", i), 32'(bus.imem_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("v%0d_wdata", i), bus.imem_wdata, vecs[i].exp_wdata);
            end
            chk($sformatf("v%0d_errc", i), 32'(bus.err_count), 32'(vecs[i].exp_errc));
            chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].exp_errc != 8'd0));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
            if (!vecs[i].last) begin
                chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'd1);
            end
`ifndef ENC_NOP_PAD_EN
            else begin
                chk($sformatf("v%0d_done", i), 32'(bus.done), 32'd1);
            end
`endif
        end

        // Full: 8 writes, then the 9th (last) beat is discarded
        wait_idle();
        start_session(12'h100);
        for (int k = 0; k < 9; k++) begin
            vec_t v;
            v = mk(0, 12'h000, 3'd1, 5'(k), 5'd0, 5'd0, 3'd0, 7'h00, 12'h000, 32'(k),
                   (k == 8), 0, 12'h000, 32'h0, 8'd0);
            @(negedge clk);
            set_beat(v);
            @(posedge clk);
            #1;
            if (k < 8) begin
                chk($sformatf("full%0d_we", k), 32'(bus.imem_we), 32'd1);
                chk($sformatf("full%0d_addr", k), 32'(bus.imem_addr), 32'h100 + 32'(k));
                chk($sformatf("full%0d_wdata", k), bus.imem_wdata,
                    (32'(k) << 20) | (32'(k) << 7) | 32'h13);
            end else begin
                chk("full_discard_we", 32'(bus.imem_we), 32'd0);
                chk("full_done", 32'(bus.done), 32'd1);
                chk("full_errc", 32'(bus.err_count), 32'd0);
            end
            if (k == 7) begin
                chk("full_flag", 32'(bus.full), 32'd1);
                chk("full_ready", 32'(bus.in_ready), 32'd0);
            end
        end
        wait_idle();
        chk("full_sticky", 32'(bus.full), 32'd1);

        // start while a session is running is ignored
        start_session(12'h050);
        @(negedge clk);
        set_beat(vecs[0]);
        bus.start     = 1'b1;
        bus.base_addr = 12'h060;
        @(posedge clk);
        #1;
        chk("restart_we", 32'(bus.imem_we), 32'd1);
        chk("restart_addr", 32'(bus.imem_addr), 32'h050);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Reset lands together with an accepted beat: the pending write is dropped
        start_session(12'h040);
        @(negedge clk);
        set_beat(vecs[0]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();

`ifdef ENC_NOP_PAD_EN
        // One beat then three NOP pad writes, done with the fourth word
        start_session(12'h200);
        @(negedge clk);
        set_beat(vecs[0]);
        @(posedge clk);
        #1;
        chk("pad0_we", 32'(bus.imem_we), 32'd1);
        chk("pad0_addr", 32'(bus.imem_addr), 32'h200);
        chk("pad0_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int p = 1; p < 4; p++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pad%0d_we", p), 32'(bus.imem_we), 32'd1);
            chk($sformatf("pad%0d_addr", p), 32'(bus.imem_addr), 32'h200 + 32'(p));
            chk($sformatf("pad%0d_wdata", p), bus.imem_wdata, 32'h00000013);
            chk($sformatf("pad%0d_done", p), 32'(bus.done), 32'(p == 3));
            chk($sformatf("pad%0d_ready", p), 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("pad_end_we", 32'(bus.imem_we), 32'd0);
        chk("pad_end_busy", 32'(bus.busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
